// File: rtl/solver_monitor_if.sv
// Result record stream from solver_monitor to a UART/ILA consumer.
// Valid/ready handshake; payload is held while stalled.
interface solver_monitor_if #(
  parameter int ANSWER_WIDTH = 64
);
  logic                    RecValid;
  logic                    RecReady;
  logic [3:0]              RecChannel;
  logic [1:0]              RecStatus;
  logic [ANSWER_WIDTH-1:0] RecAnswer;

  modport master (
    output RecValid,
    output RecChannel,
    output RecStatus,
    output RecAnswer,
    input  RecReady
  );

  modport slave (
    input  RecValid,
    input  RecChannel,
    input  RecStatus,
    input  RecAnswer,
    output RecReady
  );
endinterface

// File: rtl/solver_monitor.sv
// Multi-channel solver completion monitor with watchdog timeout.
// Latches per-channel results, then streams one record per channel.
module solver_monitor #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ANSWER_WIDTH   = 64,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                 Clk,
  input  logic                                 Rst_n,
  input  logic                                 Start,
  input  logic [NUM_CHANNELS-1:0]              ChDone,
  input  logic [NUM_CHANNELS-1:0]              ChError,
  input  logic [NUM_CHANNELS*ANSWER_WIDTH-1:0] ChAnswer,
  solver_monitor_if.master                     rec,
  output logic [CW-1:0]                        CycleCount,
  output logic                                 Busy,
  output logic                                 AllDone,
  output logic                                 Error
);

  localparam int N  = NUM_CHANNELS;
  localparam int AW = ANSWER_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_DONE = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT,
    FINISHED
  } state_e;

  state_e                 state_q;
  logic [N-1:0]           flag_q;
  logic [N-1:0]           flag_d;
  logic [N-1:0][1:0]      st_q;
  logic [N-1:0][1:0]      st_d;
  logic [N-1:0][AW-1:0]   ans_q;
  logic [N-1:0][AW-1:0]   ans_d;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_d;
  logic                   rec_valid_q;
  logic [3:0]             rec_ch_q;
  logic [1:0]             rec_st_q;
  logic [AW-1:0]          rec_ans_q;
  logic                   busy_q;
  logic                   alldone_q;
  logic                   error_q;
  logic                   all_set;
  logic                   at_limit;
  logic                   any_bad;

  // Events of the current cycle are folded in before the
  // completion and timeout decisions are taken.
  always_comb begin
    flag_d   = flag_q;
    st_d     = st_q;
    ans_d    = ans_q;
    for (int i = 0; i < N; i++) begin
      if (!flag_q[i] && ChError[i]) begin
        flag_d[i] = 1'b1;
        st_d[i]   = ST_ERR;
        ans_d[i]  = '0;
      end else if (!flag_q[i] && ChDone[i]) begin
        flag_d[i] = 1'b1;
        st_d[i]   = ST_DONE;
        ans_d[i]  = ChAnswer[i*AW +: AW];
      end
    end
    all_set  = &flag_d;
    at_limit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    if (at_limit && !all_set) begin
      for (int i = 0; i < N; i++) begin
        if (!flag_d[i]) begin
          flag_d[i] = 1'b1;
          st_d[i]   = ST_TMO;
        end
      end
    end
  end

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (st_q[i] != ST_DONE) any_bad = 1'b1;
    end
  end

  assign idx_d = idx_q + IW'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      flag_q      <= '0;
      st_q        <= '0;
      ans_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      rec_valid_q <= 1'b0;
      rec_ch_q    <= '0;
      rec_st_q    <= '0;
      rec_ans_q   <= '0;
      busy_q      <= 1'b0;
      alldone_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, FINISHED: begin
          if (Start) begin
            state_q   <= RUN;
            flag_q    <= '0;
            st_q      <= '0;
            ans_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            alldone_q <= 1'b0;
            error_q   <= 1'b0;
          end
        end
        RUN: begin
          cnt_q  <= cnt_q + CW'(1);
          flag_q <= flag_d;
          st_q   <= st_d;
          ans_q  <= ans_d;
          if (all_set || at_limit) begin
            state_q     <= REPORT;
            idx_q       <= '0;
            rec_valid_q <= 1'b1;
            rec_ch_q    <= '0;
            rec_st_q    <= st_d[0];
            rec_ans_q   <= ans_d[0];
          end
        end
        REPORT: begin
          if (rec.RecReady) begin
            if (idx_q == IW'(N - 1)) begin
              state_q     <= FINISHED;
              rec_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              alldone_q   <= 1'b1;
              error_q     <= any_bad;
            end else begin
              idx_q     <= idx_d;
              rec_ch_q  <= 4'(idx_d);
              rec_st_q  <= st_q[idx_d];
              rec_ans_q <= ans_q[idx_d];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rec.RecValid   = rec_valid_q;
  assign rec.RecChannel = rec_ch_q;
  assign rec.RecStatus  = rec_st_q;
  assign rec.RecAnswer  = rec_ans_q;
  assign CycleCount     = cnt_q;
  assign Busy           = busy_q;
  assign AllDone        = alldone_q;
  assign Error          = error_q;

endmodule

// File: tb/tb_solver_monitor.sv
// Self-checking bench for solver_monitor against a
// per-channel finish-time reference model.
module tb_solver_monitor;

  localparam int N   = 4;
  localparam int AW  = 64;
  localparam int TMO = 100;
  localparam int CW  = $clog2(TMO + 1);
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [N-1:0]    ch_done = '0;
  logic [N-1:0]    ch_error = '0;
  logic [N*AW-1:0] ch_answer = '0;
  logic [CW-1:0]   cycle_count;
  logic            busy;
  logic            all_done;
  logic            error;

  int checks = 0;
  int errors = 0;

  int          t_fin  [N];
  bit          t_err  [N];
  bit          t_both [N];
  logic [AW-1:0] t_ans [N];

  solver_monitor_if #(.ANSWER_WIDTH(AW)) rec ();

  solver_monitor #(
    .NUM_CHANNELS  (N),
    .ANSWER_WIDTH  (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Start     (start),
    .ChDone    (ch_done),
    .ChError   (ch_error),
    .ChAnswer  (ch_answer),
    .rec       (rec.master),
    .CycleCount(cycle_count),
    .Busy      (busy),
    .AllDone   (all_done),
    .Error     (error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if (rec.RecValid !== 1'b0 || rec.RecChannel !== 4'd0 ||
        rec.RecStatus !== 2'd0 || rec.RecAnswer !== '0 ||
        cycle_count !== '0 || busy !== 1'b0 ||
        all_done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s got v=%0b ch=%0d st=%0d ans=%h cc=%0d b=%0b ad=%0b e=%0b exp all zero",
               nm, rec.RecValid, rec.RecChannel, rec.RecStatus,
               rec.RecAnswer, cycle_count, busy, all_done, error);
    end
  endtask

  // rmode: 0 ready always, 1 fixed stall pattern, 2 random.
  task automatic run_case(input int rmode, input int noise,
                          input bit start_noise, input int abort_rec,
                          input string nm);
    int endc;
    bit all_in;
    logic [1:0]    est  [N];
    logic [AW-1:0] eans [N];
    bit eerr;
    int acc;
    int cyc;
    bit r;
    int pat [7] = '{0, 0, 1, 0, 1, 1, 1};

    all_in = 1'b1;
    endc   = 0;
    eerr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (t_fin[i] >= TMO) all_in = 1'b0;
      else if (t_fin[i] > endc) endc = t_fin[i];
    end
    if (!all_in) endc = TMO - 1;
    for (int i = 0; i < N; i++) begin
      if (t_fin[i] <= endc) est[i] = t_err[i] ? 2'b01 : 2'b00;
      else est[i] = 2'b10;
      eans[i] = (est[i] == 2'b00) ? t_ans[i] : '0;
      if (est[i] != 2'b00) eerr = 1'b1;
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || all_done !== 1'b0 || error !== 1'b0 ||
        cycle_count !== '0) begin
      errors++;
      $display("FAIL %s start b=%0b ad=%0b e=%0b cc=%0d exp 1 0 0 0",
               nm, busy, all_done, error, cycle_count);
    end

    for (int j = 0; j <= endc; j++) begin
      for (int i = 0; i < N; i++) begin
        ch_done[i]  = (j == t_fin[i] && (!t_err[i] || t_both[i])) ||
                      (j > t_fin[i] && $urandom_range(99) < noise);
        ch_error[i] = (j == t_fin[i] && t_err[i]) ||
                      (j > t_fin[i] && $urandom_range(99) < noise / 2);
        ch_answer[i*AW +: AW] = (j == t_fin[i]) ? t_ans[i] :
                                {$urandom, $urandom};
      end
      start = start_noise && (j == 0);
      tick();
      start = 1'b0;
      if (j < endc) begin
        checks++;
        if (rec.RecValid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s run%0d v=%0b b=%0b exp 0 1",
                   nm, j, rec.RecValid, busy);
        end
      end
    end
    ch_done  = '0;
    ch_error = '0;

    checks++;
    if (rec.RecValid !== 1'b1) begin
      errors++;
      $display("FAIL %s report_entry valid got %0b exp 1", nm, rec.RecValid);
    end
    checks++;
    if (cycle_count !== CW'(endc + 1)) begin
      errors++;
      $display("FAIL %s cycle_count got %0d exp %0d", nm, cycle_count, endc + 1);
    end

    acc = 0;
    cyc = 0;
    while (acc < N && cyc < 200) begin
      if (acc == abort_rec) begin
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs({nm, " async_reset"});
        #2 rst_n = 1'b1;
        rec.RecReady = 1'b0;
        tick();
        check_idle_outputs({nm, " after_reset"});
        return;
      end
      case (rmode)
        0: r = 1'b1;
        1: r = (cyc < 7) ? pat[cyc][0] : 1'b1;
        default: r = 1'($urandom_range(1));
      endcase
      rec.RecReady = r;
      start = start_noise && (cyc == 1);
      checks++;
      if (rec.RecValid !== 1'b1 || rec.RecChannel !== 4'(acc) ||
          rec.RecStatus !== est[acc] || rec.RecAnswer !== eans[acc]) begin
        errors++;
        $display("FAIL %s rec%0d got v=%0b ch=%0d st=%0d ans=%h exp 1 %0d %0d %h",
                 nm, acc, rec.RecValid, rec.RecChannel, rec.RecStatus,
                 rec.RecAnswer, acc, est[acc], eans[acc]);
      end
      tick();
      start = 1'b0;
      if (r) acc++;
      cyc++;
    end
    rec.RecReady = 1'b0;
    checks++;
    if (acc < N) begin
      errors++;
      $display("FAIL %s stream_timeout got %0d accepted exp %0d", nm, acc, N);
    end
    checks++;
    if (all_done !== 1'b1 || busy !== 1'b0 || error !== eerr ||
        rec.RecValid !== 1'b0) begin
      errors++;
      $display("FAIL %s finished ad=%0b b=%0b e=%0b v=%0b exp 1 0 %0b 0",
               nm, all_done, busy, error, rec.RecValid, eerr);
    end
  endtask

  task automatic clear_case;
    for (int i = 0; i < N; i++) begin
      t_fin[i]  = NEVER;
      t_err[i]  = 1'b0;
      t_both[i] = 1'b0;
      t_ans[i]  = '0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rec.RecReady = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("reset_release");
  endtask

  task automatic test_normal;
    clear_case();
    t_fin = '{5, 9, 3, 9};
    t_ans = '{64'h11, 64'h22, 64'hAB, 64'h33};
    run_case(0, 0, 1'b0, -1, "normal");
  endtask

  task automatic test_error_priority;
    clear_case();
    t_fin = '{1, 2, 6, 4};
    t_ans = '{64'h5, 64'h77, 64'h66, 64'h44};
    t_err[1]  = 1'b1;
    t_both[1] = 1'b1;
    run_case(0, 100, 1'b0, -1, "err_prio");
  endtask

  task automatic test_timeout;
    clear_case();
    t_fin = '{10, NEVER, TMO - 1, NEVER};
    t_ans = '{64'hA0A0, 64'h1, 64'hC2C2, 64'h3};
    run_case(2, 20, 1'b0, -1, "timeout");
  endtask

  task automatic test_backpressure;
    clear_case();
    for (int i = 0; i < N; i++) begin
      t_fin[i] = $urandom_range(12);
      t_ans[i] = {$urandom, $urandom};
    end
    run_case(1, 30, 1'b0, -1, "backpressure");
  endtask

  task automatic test_restart_ignore;
    clear_case();
    t_fin = '{2, 4, 3, 1};
    t_ans = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
    t_err[3] = 1'b1;
    run_case(1, 0, 1'b1, -1, "ignore_start");
    clear_case();
    t_fin = '{7, 0, 5, 2};
    t_ans = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
    run_case(0, 0, 1'b0, -1, "restart");
  endtask

  task automatic test_async_reset;
    clear_case();
    t_fin = '{1, 2, 3, 4};
    t_ans = '{64'hF0, 64'hF1, 64'hF2, 64'hF3};
    run_case(0, 0, 1'b0, 2, "async_rst");
    clear_case();
    t_fin = '{3, 3, 0, 6};
    t_ans = '{64'h90, 64'h91, 64'h92, 64'h93};
    run_case(0, 0, 1'b0, -1, "post_reset");
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      clear_case();
      for (int i = 0; i < N; i++) begin
        t_fin[i]  = ($urandom_range(9) == 0) ? NEVER : $urandom_range(30);
        t_err[i]  = ($urandom_range(3) == 0);
        t_both[i] = 1'($urandom_range(1));
        t_ans[i]  = {$urandom, $urandom};
      end
      run_case(2, 25, 1'($urandom_range(1)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_error_priority();
    test_timeout();
    test_backpressure();
    test_restart_ignore();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
